// File: rtl/ms_reveal.sv
// ms_reveal: flood-fill reveal engine for the 8x8 minesweeper board.
// Opens one cell per accepted request and, when that cell has no
// neighbouring mines, grows the revealed region one ring per cycle
// across connected zero cells and their borders.
module ms_reveal #(
    parameter int MAX_SWEEPS = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_start,
    input  logic [5:0]  i_cell_idx,
    input  logic [63:0] i_mine,
    input  logic [63:0] i_is_zero,
    input  logic [63:0] i_flag,
    output logic [63:0] o_revealed,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_hit_mine,
    output logic        o_win
);

    localparam int              CNT_W    = $clog2(MAX_SWEEPS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_SWEEPS - 1);

    // Column 0 and column 7 cells; sources in these columns must not
    // contribute across the row boundary.
    localparam logic [63:0] COL0 = 64'h0101_0101_0101_0101;
    localparam logic [63:0] COL7 = 64'h8080_8080_8080_8080;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_SWEEP,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [5:0]        r_cell;
    logic [63:0]       r_revealed;
    logic [63:0]       r_front;
    logic [CNT_W-1:0]  r_count;
    logic              r_hit_mine;

    logic [63:0]       w_sel;
    logic              w_sel_blocked;
    logic              w_sel_mine;
    logic              w_accept;
    logic [63:0]       w_src;
    logic [63:0]       w_src_no7;
    logic [63:0]       w_src_no0;
    logic [63:0]       w_nbr;
    logic [63:0]       w_new;

    // Target-cell decode and king-move neighbour expansion of the frontier.
    // Only zero cells in the frontier propagate; a shift that moves a cell
    // right (+1, -7, +9) drops column 7 sources, a shift that moves it
    // left (-1, +7, -9) drops column 0 sources.
    always_comb begin
        w_sel         = 64'd1 << r_cell;
        w_sel_blocked = i_flag[r_cell] | r_revealed[r_cell];
        w_sel_mine    = i_mine[r_cell];
        w_accept      = i_start & ~r_hit_mine;
        w_src         = r_front & i_is_zero;
        w_src_no7     = w_src & ~COL7;
        w_src_no0     = w_src & ~COL0;
        w_nbr         = (w_src_no7 << 1) | (w_src_no0 >> 1)
                      | (w_src_no0 << 7) | (w_src_no7 >> 7)
                      | (w_src     << 8) | (w_src     >> 8)
                      | (w_src_no7 << 9) | (w_src_no0 >> 9);
        w_new         = w_nbr & ~r_revealed & ~i_mine & ~i_flag;
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; clear overrides everything and returns to IDLE.
    always_comb begin
        w_next_state = r_state;
        if (i_clear) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_next_state = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_sel_blocked || w_sel_mine) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    if ((w_new == 64'd0) || (r_count == CNT_LAST)) begin
                        w_next_state = S_DONE;
                    end
                end
                S_DONE: begin
                    w_next_state = S_IDLE;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // Board state: revealed map, frontier, sweep counter and mine status.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cell     <= 6'd0;
            r_revealed <= 64'd0;
            r_front    <= 64'd0;
            r_count    <= '0;
            r_hit_mine <= 1'b0;
        end else if (i_clear) begin
            r_revealed <= 64'd0;
            r_front    <= 64'd0;
            r_count    <= '0;
            r_hit_mine <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cell <= i_cell_idx;
                    end
                end
                S_CHECK: begin
                    if (!w_sel_blocked) begin
                        r_revealed <= r_revealed | w_sel;
                        if (w_sel_mine) begin
                            r_hit_mine <= 1'b1;
                        end else begin
                            r_front <= w_sel;
                        end
                    end
                end
                S_SWEEP: begin
                    r_revealed <= r_revealed | w_new;
                    r_front    <= w_new;
                    r_count    <= r_count + 1'b1;
                end
                S_DONE: begin
                    r_front <= 64'd0;
                    r_count <= '0;
                end
                default: begin
                    r_front <= 64'd0;
                end
            endcase
        end
    end

    // Status outputs.
    always_comb begin
        o_revealed = r_revealed;
        o_busy     = (r_state != S_IDLE);
        o_done     = (r_state == S_DONE);
        o_hit_mine = r_hit_mine;
        o_win      = (&(r_revealed | i_mine)) & ~r_hit_mine;
    end

endmodule

// File: tb/tb_ms_reveal.sv
// tb_ms_reveal: directed-vector bench for the minesweeper reveal engine.
module tb_ms_reveal;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_clear;
    logic        i_start;
    logic [5:0]  i_cell_idx;
    logic [63:0] i_mine;
    logic [63:0] i_is_zero;
    logic [63:0] i_flag;
    logic [63:0] o_revealed;
    logic        o_busy;
    logic        o_done;
    logic        o_hit_mine;
    logic        o_win;

    int checks;
    int errors;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] COL0 = 64'h0101_0101_0101_0101;
    localparam logic [63:0] COL1 = 64'h0202_0202_0202_0202;
    localparam logic [63:0] COL6 = 64'h4040_4040_4040_4040;
    localparam logic [63:0] COL7 = 64'h8080_8080_8080_8080;

    ms_reveal #(.MAX_SWEEPS(64)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (i_clear),
        .i_start    (i_start),
        .i_cell_idx (i_cell_idx),
        .i_mine     (i_mine),
        .i_is_zero  (i_is_zero),
        .i_flag     (i_flag),
        .o_revealed (o_revealed),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_hit_mine (o_hit_mine),
        .o_win      (o_win)
    );

    // 10 ns clock; inputs change and outputs are sampled on the falling edge.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Issue one open request and return the cycle (relative to the
    // accepting edge k) in which done is seen; -1 if it never arrives.
    task automatic open_cell(input logic [5:0] c, output int lat);
        @(negedge i_clk);
        i_start    = 1'b1;
        i_cell_idx = c;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        lat = 1;
        while (!o_done && lat < 100) begin
            @(negedge i_clk);
            lat++;
        end
        if (!o_done) lat = -1;
    endtask

    // New-game clear pulse covering one rising edge.
    task automatic do_clear();
        @(negedge i_clk);
        i_clear = 1'b1;
        @(negedge i_clk);
        i_clear = 1'b0;
    endtask

    // Reset state.
    task automatic test_reset();
        i_rst_n = 1'b0;
        i_clear = 1'b0; i_start = 1'b0; i_cell_idx = 6'd0;
        i_mine = 64'd0; i_is_zero = 64'd0; i_flag = 64'd0;
        #12;
        checks++; if (o_revealed !== 64'd0) begin errors++; $display("[TB] FAIL reset_revealed got %h want %h", o_revealed, 64'd0); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", o_done); end
        checks++; if (o_hit_mine !== 1'b0) begin errors++; $display("[TB] FAIL reset_hit got %b want 0", o_hit_mine); end
        checks++; if (o_win !== 1'b0) begin errors++; $display("[TB] FAIL reset_win got %b want 0", o_win); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // Empty board flood from the corner: whole board in 7 rings + 1 empty sweep.
    task automatic test_empty_board();
        int lat;
        do_clear();
        i_mine = 64'd0; i_is_zero = ALL1; i_flag = 64'd0;
        open_cell(6'd0, lat);
        checks++; if (lat !== 10) begin errors++; $display("[TB] FAIL empty_latency got %0d want 10", lat); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("[TB] FAIL empty_busy_in_done got %b want 1", o_busy); end
        checks++; if (o_revealed !== ALL1) begin errors++; $display("[TB] FAIL empty_revealed got %h want %h", o_revealed, ALL1); end
        checks++; if (o_win !== 1'b1) begin errors++; $display("[TB] FAIL empty_win got %b want 1", o_win); end
        checks++; if (o_hit_mine !== 1'b0) begin errors++; $display("[TB] FAIL empty_hit got %b want 0", o_hit_mine); end
        @(negedge i_clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL empty_idle_busy got %b want 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("[TB] FAIL empty_done_pulse got %b want 0", o_done); end
    endtask

    // Single mine in the far corner; its three neighbours become borders.
    task automatic test_corner_mine();
        int lat;
        do_clear();
        i_mine = 64'h8000_0000_0000_0000;
        i_is_zero = ~64'h40C0_0000_0000_0000;
        i_flag = 64'd0;
        open_cell(6'd0, lat);
        checks++; if (lat !== 10) begin errors++; $display("[TB] FAIL corner_latency got %0d want 10", lat); end
        checks++; if (o_revealed !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL corner_revealed got %h want %h", o_revealed, 64'h7FFF_FFFF_FFFF_FFFF); end
        checks++; if (o_win !== 1'b1) begin errors++; $display("[TB] FAIL corner_win got %b want 1", o_win); end
    endtask

    // Numbered cell, mine hit, and frozen board afterwards.
    task automatic test_mine_hit();
        int lat;
        logic sawActivity;
        do_clear();
        i_mine = 64'h0000_0000_0000_0200;
        i_is_zero = ~64'h0000_0000_0007_0507;
        i_flag = 64'd0;
        open_cell(6'd0, lat);
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL num_latency got %0d want 3", lat); end
        checks++; if (o_revealed !== 64'h1) begin errors++; $display("[TB] FAIL num_revealed got %h want %h", o_revealed, 64'h1); end
        open_cell(6'd9, lat);
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL hit_latency got %0d want 2", lat); end
        checks++; if (o_revealed !== 64'h201) begin errors++; $display("[TB] FAIL hit_revealed got %h want %h", o_revealed, 64'h201); end
        checks++; if (o_hit_mine !== 1'b1) begin errors++; $display("[TB] FAIL hit_flag got %b want 1", o_hit_mine); end
        checks++; if (o_win !== 1'b0) begin errors++; $display("[TB] FAIL hit_win got %b want 0", o_win); end
        @(negedge i_clk);
        i_start = 1'b1; i_cell_idx = 6'd5;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        sawActivity = o_busy | o_done;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            sawActivity = sawActivity | o_busy | o_done;
        end
        checks++; if (sawActivity !== 1'b0) begin errors++; $display("[TB] FAIL frozen_activity got %b want 0", sawActivity); end
        checks++; if (o_revealed !== 64'h201) begin errors++; $display("[TB] FAIL frozen_revealed got %h want %h", o_revealed, 64'h201); end
        do_clear();
        checks++; if (o_hit_mine !== 1'b0) begin errors++; $display("[TB] FAIL clear_hit got %b want 0", o_hit_mine); end
        checks++; if (o_revealed !== 64'd0) begin errors++; $display("[TB] FAIL clear_revealed got %h want %h", o_revealed, 64'd0); end
    endtask

    // Flags block reveal and expansion; opening a flagged cell is a no-op.
    task automatic test_flag();
        int lat;
        do_clear();
        i_mine = 64'd0; i_is_zero = ALL1; i_flag = 64'h200;
        open_cell(6'd0, lat);
        checks++; if (o_revealed !== ~64'h200) begin errors++; $display("[TB] FAIL flag_revealed got %h want %h", o_revealed, ~64'h200); end
        open_cell(6'd9, lat);
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL flag_open_latency got %0d want 2", lat); end
        checks++; if (o_revealed !== ~64'h200) begin errors++; $display("[TB] FAIL flag_open_revealed got %h want %h", o_revealed, ~64'h200); end
        open_cell(6'd0, lat);
        checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL reopen_latency got %0d want 2", lat); end
    endtask

    // Mine at column 0 row 1, flood from column 7 row 0: no wrap into cell 0 or 8.
    task automatic test_row_wrap();
        int lat;
        do_clear();
        i_mine = 64'h100;
        i_is_zero = ~64'h0000_0000_0003_0303;
        i_flag = 64'd0;
        open_cell(6'd7, lat);
        checks++; if (lat !== 10) begin errors++; $display("[TB] FAIL wrap_latency got %0d want 10", lat); end
        checks++; if (o_revealed !== 64'hFFFF_FFFF_FFFF_FEFE) begin errors++; $display("[TB] FAIL wrap_revealed got %h want %h", o_revealed, 64'hFFFF_FFFF_FFFF_FEFE); end
        checks++; if (o_win !== 1'b0) begin errors++; $display("[TB] FAIL wrap_win_partial got %b want 0", o_win); end
        open_cell(6'd0, lat);
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL wrap_cell0_latency got %0d want 3", lat); end
        checks++; if (o_revealed !== 64'hFFFF_FFFF_FFFF_FEFF) begin errors++; $display("[TB] FAIL wrap_final_revealed got %h want %h", o_revealed, 64'hFFFF_FFFF_FFFF_FEFF); end
        checks++; if (o_win !== 1'b1) begin errors++; $display("[TB] FAIL wrap_win got %b want 1", o_win); end
    endtask

    // Flag walls confine the flood to a single edge column.
    task automatic test_column_masks();
        int lat;
        do_clear();
        i_mine = 64'd0; i_is_zero = ALL1; i_flag = COL1 | COL6;
        open_cell(6'd0, lat);
        checks++; if (lat !== 10) begin errors++; $display("[TB] FAIL col0_latency got %0d want 10", lat); end
        checks++; if (o_revealed !== COL0) begin errors++; $display("[TB] FAIL col0_revealed got %h want %h", o_revealed, COL0); end
        do_clear();
        open_cell(6'd7, lat);
        checks++; if (lat !== 10) begin errors++; $display("[TB] FAIL col7_latency got %0d want 10", lat); end
        checks++; if (o_revealed !== COL7) begin errors++; $display("[TB] FAIL col7_revealed got %h want %h", o_revealed, COL7); end
    endtask

    // Clear mid-flood aborts without a done pulse.
    task automatic test_clear_abort();
        logic sawDone;
        do_clear();
        i_mine = 64'd0; i_is_zero = ALL1; i_flag = 64'd0;
        @(negedge i_clk);
        i_start = 1'b1; i_cell_idx = 6'd0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        sawDone = o_done;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            sawDone = sawDone | o_done;
        end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_busy_before got %b want 1", o_busy); end
        i_clear = 1'b1;
        @(negedge i_clk);
        i_clear = 1'b0;
        checks++; if (o_revealed !== 64'd0) begin errors++; $display("[TB] FAIL abort_revealed got %h want %h", o_revealed, 64'd0); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b want 0", o_busy); end
        for (int i = 0; i < 10; i++) begin
            sawDone = sawDone | o_done;
            @(negedge i_clk);
        end
        checks++; if (sawDone !== 1'b0) begin errors++; $display("[TB] FAIL abort_done got %b want 0", sawDone); end
    endtask

    // A start held high while busy is dropped, then a fresh open follows.
    task automatic test_back_to_back();
        int lat;
        do_clear();
        i_mine = 64'h0000_0000_0000_0200;
        i_is_zero = ~64'h0000_0000_0007_0507;
        i_flag = 64'd0;
        @(negedge i_clk);
        i_start = 1'b1; i_cell_idx = 6'd0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_cell_idx = 6'd63;
        @(negedge i_clk);
        @(negedge i_clk);
        checks++; if (o_done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done got %b want 1", o_done); end
        i_start = 1'b0;
        @(negedge i_clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle got %b want 0", o_busy); end
        checks++; if (o_revealed !== 64'h1) begin errors++; $display("[TB] FAIL b2b_dropped got %h want %h", o_revealed, 64'h1); end
        open_cell(6'd2, lat);
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL b2b_second_latency got %0d want 3", lat); end
        checks++; if (o_revealed !== 64'h5) begin errors++; $display("[TB] FAIL b2b_second_revealed got %h want %h", o_revealed, 64'h5); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_empty_board();
        test_corner_mine();
        test_mine_hit();
        test_flag();
        test_row_wrap();
        test_column_masks();
        test_clear_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
